// File: rtl/data_mem_responder.sv
// data_mem_responder: protocol-correct data-memory target for the core's
// request/grant/rvalid data port. Grants after WaitStates cycles, performs
// byte-enabled writes or word reads on a local word array, and returns one
// registered response per grant.
// Optional: define DATA_MEM_RESP_STATS_EN to add saturating access counters.
module data_mem_responder #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          MemDepth   = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int unsigned          WaitStates = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o
`ifdef DATA_MEM_RESP_STATS_EN
  ,
  output logic [31:0]          rd_count_o,
  output logic [31:0]          wr_count_o,
  output logic [31:0]          err_count_o
`endif
);

  localparam int unsigned IdxW    = $clog2(MemDepth);
  localparam logic [3:0]  WaitCnt = 4'(WaitStates);
  localparam logic [63:0] Base64  = 64'(BaseAddr);
  localparam logic [63:0] Span64  = 64'(MemDepth) << 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGrant
  } state_e;

  state_e            state;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              gnt;
  logic [63:0]       addr64, off64;
  logic              in_range;
  logic [IdxW-1:0]   idx;
  logic              rd_en, wr_en;

  logic [31:0]       mem_q [MemDepth];

  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Classify the current cycle from the request and the wait counter, and
  // compute the counter's next value.
  always_comb begin
    state  = StIdle;
    wcnt_d = '0;
    if (data_req_i) begin
      if (wcnt_q == WaitCnt) begin
        state = StGrant;
      end else begin
        state  = StWait;
        wcnt_d = wcnt_q + 4'd1;
      end
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign gnt        = (state == StGrant) & ~rst_i;
  assign data_gnt_o = gnt;

  // Range check in 64 bits so BaseAddr + span cannot wrap.
  assign addr64   = 64'(data_addr_i);
  assign off64    = addr64 - Base64;
  assign in_range = (addr64 >= Base64) && (off64 < Span64);
  assign idx      = off64[IdxW+1:2];

  assign rd_en = gnt & ~data_we_i & in_range;
  assign wr_en = gnt &  data_we_i & in_range;

  // Byte-enabled array write at the grant edge; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Registered response, one cycle after each grant; fields idle at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & ~in_range;
      rdata_q  <= rd_en ? mem_q[idx] : '0;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

`ifdef DATA_MEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, err_cnt_q;
  logic        oor_en;

  assign oor_en = gnt & ~in_range;

  // Saturating access statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (rd_en && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (wr_en && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      if (oor_en && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: two instances (0 and 3 wait states,
// different base addresses) checked every cycle against a behavioural model,
// plus directed transactions with literal expected values.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req0, gnt0, we0, rv0, err0;
  logic [3:0]  be0;
  logic [31:0] a0, wd0, rd0;
  logic        req3, gnt3, we3, rv3, err3;
  logic [3:0]  be3;
  logic [31:0] a3, wd3, rd3;
`ifdef DATA_MEM_RESP_STATS_EN
  logic [31:0] rc0, wc0, ec0, rc3, wc3, ec3;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .AddrWidth(32), .MemDepth(DEPTH), .BaseAddr(BASE0), .WaitStates(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req0), .data_gnt_o(gnt0), .data_we_i(we0), .data_be_i(be0),
    .data_addr_i(a0), .data_wdata_i(wd0),
    .data_rvalid_o(rv0), .data_rdata_o(rd0), .data_err_o(err0)
`ifdef DATA_MEM_RESP_STATS_EN
    , .rd_count_o(rc0), .wr_count_o(wc0), .err_count_o(ec0)
`endif
  );

  data_mem_responder #(
    .AddrWidth(32), .MemDepth(DEPTH), .BaseAddr(BASE3), .WaitStates(3)
  ) dut3 (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req3), .data_gnt_o(gnt3), .data_we_i(we3), .data_be_i(be3),
    .data_addr_i(a3), .data_wdata_i(wd3),
    .data_rvalid_o(rv3), .data_rdata_o(rd3), .data_err_o(err3)
`ifdef DATA_MEM_RESP_STATS_EN
    , .rd_count_o(rc3), .wr_count_o(wc3), .err_count_o(ec3)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [2][DEPTH];
  bit          ev [2];
  logic [31:0] ed [2];
  bit          ee [2];
  int unsigned cnt [2][3];   // reads, writes, out-of-range
  int          held;         // cycles dut3's request has waited so far

  task automatic step(input int k, input bit g, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd);
    longint unsigned a, b, w;
    a = addr;
    b = (k == 0) ? BASE0 : BASE3;
    ev[k] = g; ed[k] = '0; ee[k] = 1'b0;
    if (!g) return;
    if (a < b || a >= b + 4 * DEPTH) begin
      ee[k] = 1'b1;
      cnt[k][2]++;
    end else begin
      w = (a - b) / 4;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mm[k][w][8*i +: 8] = wd[8*i +: 8];
        cnt[k][1]++;
      end else begin
        ed[k] = mm[k][w];
        cnt[k][0]++;
      end
    end
  endtask

  initial begin
    bit g3;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 0; ed[k] = '0; ee[k] = 0;
      for (int j = 0; j < 3; j++) cnt[k][j] = 0;
    end
    held = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          ev[k] = 0; ed[k] = '0; ee[k] = 0;
          for (int j = 0; j < 3; j++) cnt[k][j] = 0;
        end
        held = 0;
      end else begin
        g3 = req3 && (held == 3);
        step(0, req0, we0, be0, a0, wd0);
        step(1, g3, we3, be3, a3, wd3);
        held = (!req3 || g3) ? 0 : held + 1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    #3;
    forever begin
      @(negedge clk);
      chk("gnt0",    gnt0, req0 && !rst);
      chk("rvalid0", rv0,  ev[0]);
      chk("rdata0",  rd0,  ed[0]);
      chk("err0",    err0, ee[0]);
      chk("gnt3",    gnt3, req3 && (held == 3) && !rst);
      chk("rvalid3", rv3,  ev[1]);
      chk("rdata3",  rd3,  ed[1]);
      chk("err3",    err3, ee[1]);
`ifdef DATA_MEM_RESP_STATS_EN
      chk("rd_count0",  rc0, cnt[0][0]);
      chk("wr_count0",  wc0, cnt[0][1]);
      chk("err_count0", ec0, cnt[0][2]);
      chk("rd_count3",  rc3, cnt[1][0]);
      chk("wr_count3",  wc3, cnt[1][1]);
      chk("err_count3", ec3, cnt[1][2]);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = we; be0 = be; a0 = addr; wd0 = wd;
    @(negedge clk);
    chk("x0_gnt_same_cycle", gnt0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("x0_rvalid_next", rv0, 1'b1);
    rdata = rd0;
    err   = err0;
  endtask

  task automatic wait_gnt3(output int cg, output bit found);
    found = 0; cg = 0;
    for (int n = 0; n < 12 && !found; n++) begin
      @(negedge clk);
      if (gnt3) begin
        found = 1;
        cg    = cyc;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          c0, c1, cg, rvn;
    bit          found;
`ifdef DATA_MEM_RESP_STATS_EN
    logic [31:0] rc_b, wc_b;
`endif
    req0 = 0; we0 = 0; be0 = '0; a0 = '0; wd0 = '0;
    req3 = 0; we3 = 0; be3 = '0; a3 = '0; wd3 = '0;

    // Reset: outputs idle, grant suppressed even with a request present.
    #2 rst = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b1;
    @(negedge clk);
    chk("rst_gnt0_blocked", gnt0, 1'b0);
    chk("rst_rvalid0", rv0, 1'b0);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_err0", err0, 1'b0);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst  = 1'b0;

    // Word write then read.
    xfer0(1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF, rd, er);
    chk("wr_rdata_zero", rd, 32'h0);
    chk("wr_err_zero", er, 1'b0);
    xfer0(1'b0, 4'hF, 32'h8, 32'h0, rd, er);
    chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
    chk("rd_err_zero", er, 1'b0);

    // Byte enables, including an all-zero enable write.
    xfer0(1'b1, 4'hF, 32'h0, 32'h0, rd, er);
    xfer0(1'b1, 4'b0101, 32'h0, 32'h1122_3344, rd, er);
    xfer0(1'b0, 4'h0, 32'h0, 32'h0, rd, er);
    chk("be_0101", rd, 32'h0022_0044);
    xfer0(1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF, rd, er);
    chk("be_zero_no_err", er, 1'b0);
    xfer0(1'b0, 4'hF, 32'h0, 32'h0, rd, er);
    chk("be_zero_unchanged", rd, 32'h0022_0044);

    // Out of range: first address past the array.
    xfer0(1'b0, 4'hF, 32'd64, 32'h0, rd, er);
    chk("oor_rd_err", er, 1'b1);
    chk("oor_rd_data", rd, 32'h0);
    xfer0(1'b1, 4'hF, 32'd64, 32'hFFFF_FFFF, rd, er);
    chk("oor_wr_err", er, 1'b1);
    chk("oor_wr_data", rd, 32'h0);
    xfer0(1'b0, 4'hF, 32'h0, 32'h0, rd, er);
    chk("oor_word0_intact", rd, 32'h0022_0044);
`ifdef DATA_MEM_RESP_STATS_EN
    chk("err_count_2", ec0, 32'd2);
    rc_b = rc0;
    wc_b = wc0;
`endif

    // Streaming: 8 writes then 8 reads, back to back, words 4..11.
    rvn = 0;
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i < 16) begin
        req0 = 1'b1;
        we0  = (i < 8);
        be0  = 4'hF;
        a0   = 32'(4 * (4 + (i % 8)));
        wd0  = 32'hA000_0000 + 32'(i);
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        if (rv0) rvn++;
        if (i > 8) chk("stream_rdata", rd0, 32'hA000_0000 + 32'(i - 9));
      end
    end
    chk("stream_rvalid_count", rvn, 16);
`ifdef DATA_MEM_RESP_STATS_EN
    chk("stream_wr_count", wc0 - wc_b, 32'd8);
    chk("stream_rd_count", rc0 - rc_b, 32'd8);
`endif

    // WaitStates = 3: grant 3 cycles after the request rises.
    @(posedge clk); #1;
    req3 = 1'b1; we3 = 1'b1; be3 = 4'hF; a3 = 32'h1004; wd3 = 32'hCAFE_0001;
    c0 = cyc;
    wait_gnt3(cg, found);
    chk("ws3_gnt_seen", found, 1'b1);
    chk("ws3_gnt_latency", cg - c0, 3);
    @(posedge clk); #1;
    req3 = 1'b0;
    @(negedge clk);
    chk("ws3_rvalid_cycle", cyc - c0, 4);
    chk("ws3_rvalid", rv3, 1'b1);
    chk("ws3_wr_err", err3, 1'b0);

    // Request dropped at cycle 2 restarts the wait.
    @(posedge clk); #1;
    req3 = 1'b1; we3 = 1'b0; a3 = 32'h1004;
    c0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #1;
    req3 = 1'b1;
    c1 = cyc;
    chk("ws3_reraise_cycle", c1 - c0, 3);
    wait_gnt3(cg, found);
    chk("ws3_regnt_seen", found, 1'b1);
    chk("ws3_regnt_latency", cg - c1, 3);
    @(posedge clk); #1;
    req3 = 1'b0;
    @(negedge clk);
    chk("ws3_rd_data", rd3, 32'hCAFE_0001);

    // Below a non-zero base is out of range.
    @(posedge clk); #1;
    req3 = 1'b1; we3 = 1'b0; a3 = 32'h0FFC;
    wait_gnt3(cg, found);
    chk("ws3_low_gnt_seen", found, 1'b1);
    @(posedge clk); #1;
    req3 = 1'b0;
    @(negedge clk);
    chk("ws3_low_err", err3, 1'b1);
    chk("ws3_low_rdata", rd3, 32'h0);

    // Reset with a read response in flight.
    xfer0(1'b1, 4'hF, 32'd48, 32'h5A5A_1234, rd, er);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; a0 = 32'd48;
    @(negedge clk);
    chk("mid_rst_gnt", gnt0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    chk("mid_rst_rvalid_before", rv0, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid_drop", rv0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rvalid", rv0, 1'b0);
    end
    xfer0(1'b0, 4'hF, 32'd48, 32'h0, rd, er);
    chk("post_rst_word_intact", rd, 32'h5A5A_1234);
    xfer0(1'b0, 4'hF, 32'h8, 32'h0, rd, er);
    chk("post_rst_deadbeef", rd, 32'hDEAD_BEEF);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
